// File: rtl/ibus_fetch_bridge_pkg.sv
// Shared types and constants for the fetch-side instruction bus bridge.
package ibus_fetch_bridge_pkg;

  localparam int unsigned XLEN = 32;

  typedef logic [XLEN-1:0] word_t;
  typedef logic [XLEN-1:0] instr_t;

  localparam instr_t     BUBBLE_INSTR = 32'h0000_0000;
  localparam logic [1:0] SIZE_WORD    = 2'b10;

  typedef enum logic [2:0] {
    StIdle,
    StWaitAddr,
    StWaitData,
    StHold,
    StDiscard
  } ibus_state_t;

  typedef struct packed {
    logic       req;
    logic       wr;
    logic [1:0] size;
    word_t      addr;
  } ibus_req_t;

  typedef struct packed {
    logic  addr_ok;
    logic  data_ok;
    word_t rdata;
  } ibus_resp_t;

  function automatic logic is_misaligned(input logic [1:0] pc_lo);
    return pc_lo != 2'b00;
  endfunction

endpackage

// File: rtl/ibus_fetch_bridge_if.sv
// Fetch-stage and instruction-bus signals seen by the bridge (slave) and its environment (master).
interface ibus_fetch_bridge_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);

  logic              req;
  logic [ADDR_W-1:0] pc;
  logic              stall_in;
  logic              flush;
  logic [DATA_W-1:0] raw_instr;
  logic              instr_valid;
  logic              addr_err;
  logic              stall_out;

  logic              inst_req;
  logic              inst_wr;
  logic [1:0]        inst_size;
  logic [ADDR_W-1:0] inst_addr;
  logic              inst_addr_ok;
  logic              inst_data_ok;
  logic [DATA_W-1:0] inst_rdata;

  modport slave (
    input  req, pc, stall_in, flush, inst_addr_ok, inst_data_ok, inst_rdata,
    output raw_instr, instr_valid, addr_err, stall_out,
    output inst_req, inst_wr, inst_size, inst_addr
  );

  modport master (
    output req, pc, stall_in, flush, inst_addr_ok, inst_data_ok, inst_rdata,
    input  raw_instr, instr_valid, addr_err, stall_out,
    input  inst_req, inst_wr, inst_size, inst_addr
  );

endinterface

// File: rtl/ibus_fetch_bridge.sv
// Memory end of the fetch interface: one outstanding SRAM-like read at a time, with
// freeze hold buffer, flush discard and misaligned-PC bubbles.
module ibus_fetch_bridge #(
  parameter int unsigned       ADDR_W       = 32,
  parameter int unsigned       DATA_W       = 32,
  parameter logic [DATA_W-1:0] BUBBLE_INSTR = '0
) (
  input  logic                 clk,
  input  logic                 resetn,
  ibus_fetch_bridge_if.slave   io_bus
);

  import ibus_fetch_bridge_pkg::*;

  ibus_state_t       r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [DATA_W-1:0] r_buf, w_buf_nxt;
  logic              r_flush_seen, w_flush_seen_nxt;

  logic              w_inst_req;
  logic [ADDR_W-1:0] w_inst_addr;
  logic [DATA_W-1:0] w_raw_instr;
  logic              w_instr_valid;
  logic              w_addr_err;
  logic              w_stall_out;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= StIdle;
      r_addr       <= '0;
      r_buf        <= '0;
      r_flush_seen <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_addr       <= w_addr_nxt;
      r_buf        <= w_buf_nxt;
      r_flush_seen <= w_flush_seen_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_addr_nxt       = r_addr;
    w_buf_nxt        = r_buf;
    w_flush_seen_nxt = r_flush_seen;
    w_inst_req       = 1'b0;
    w_inst_addr      = r_addr;
    w_raw_instr      = BUBBLE_INSTR;
    w_instr_valid    = 1'b0;
    w_addr_err       = 1'b0;
    w_stall_out      = 1'b0;

    // Gate the combinational IDLE request path so outputs sit at reset values while reset is low.
    if (resetn) begin
      unique case (r_state)
        StIdle: begin
          w_flush_seen_nxt = 1'b0;
          if (io_bus.req && !io_bus.flush) begin
            if (is_misaligned(io_bus.pc[1:0])) begin
              w_instr_valid = 1'b1;
              w_addr_err    = 1'b1;
            end else begin
              w_inst_req  = 1'b1;
              w_inst_addr = io_bus.pc;
              w_stall_out = 1'b1;
              w_addr_nxt  = io_bus.pc;
              w_state_nxt = io_bus.inst_addr_ok ? StWaitData : StWaitAddr;
            end
          end
        end

        StWaitAddr: begin
          w_inst_req  = 1'b1;
          w_stall_out = 1'b1;
          if (io_bus.flush) w_flush_seen_nxt = 1'b1;
          if (io_bus.inst_addr_ok) begin
            w_state_nxt = (r_flush_seen || io_bus.flush) ? StDiscard : StWaitData;
          end
        end

        StWaitData: begin
          w_stall_out = 1'b1;
          if (io_bus.inst_data_ok) begin
            w_stall_out = 1'b0;
            if (io_bus.flush) begin
              w_state_nxt = StIdle;
            end else begin
              w_raw_instr   = io_bus.inst_rdata;
              w_instr_valid = 1'b1;
              if (io_bus.stall_in) begin
                w_buf_nxt   = io_bus.inst_rdata;
                w_state_nxt = StHold;
              end else begin
                w_state_nxt = StIdle;
              end
            end
          end else if (io_bus.flush) begin
            w_state_nxt = StDiscard;
          end
        end

        StHold: begin
          if (io_bus.flush) begin
            w_buf_nxt   = '0;
            w_state_nxt = StIdle;
          end else begin
            w_raw_instr   = r_buf;
            w_instr_valid = 1'b1;
            if (!io_bus.stall_in) w_state_nxt = StIdle;
          end
        end

        StDiscard: begin
          if (io_bus.inst_data_ok) w_state_nxt = StIdle;
        end

        default: w_state_nxt = StIdle;
      endcase
    end
  end

  assign io_bus.inst_req    = w_inst_req;
  assign io_bus.inst_wr     = 1'b0;
  assign io_bus.inst_size   = SIZE_WORD;
  assign io_bus.inst_addr   = w_inst_addr;
  assign io_bus.raw_instr   = w_raw_instr;
  assign io_bus.instr_valid = w_instr_valid;
  assign io_bus.addr_err    = w_addr_err;
  assign io_bus.stall_out   = w_stall_out;

endmodule
